// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter that shares the register file's single write port among NUM_REQ write-back requesters.
// Latency: 1 cycle from grant (valid & ready at posedge) to rf_write_enable/rf_dest_addr/rf_write_data.
// Backpressure: stall or reset withholds every req_ready; no buffering beyond the single output register.
// Optional read forwarding of the in-flight write is enabled by defining REGFILE_WB_FWD_EN.
module regfile_wb_arbiter #(
  parameter int BIT_NUMBER      = 64,
  parameter int ADDR_NUMBER     = 5,
  parameter int REGISTER_NUMBER = 16,
  parameter int NUM_REQ         = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           stall,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*ADDR_NUMBER-1:0] req_addr,
  input  logic [NUM_REQ*BIT_NUMBER-1:0]  req_data,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic                           rf_enable,
  output logic                           rf_write_enable,
  output logic [ADDR_NUMBER-1:0]         rf_dest_addr,
  output logic [BIT_NUMBER-1:0]          rf_write_data,
  output logic                           err_addr,
  input  logic [ADDR_NUMBER-1:0]         rd_addr_1,
  input  logic [ADDR_NUMBER-1:0]         rd_addr_2,
  output logic                           fwd_hit_1,
  output logic                           fwd_hit_2,
  output logic [BIT_NUMBER-1:0]          fwd_data
);

  localparam int PTR_W = (NUM_REQ > 2) ? 2 : 1;
  // One extra bit so REGISTER_NUMBER == 2**ADDR_NUMBER still fits.
  localparam logic [ADDR_NUMBER:0] ADDR_LIMIT = (ADDR_NUMBER+1)'(REGISTER_NUMBER);

  logic [PTR_W-1:0]       ptr_q, ptr_d;
  logic                   rf_write_enable_q, rf_write_enable_d;
  logic [ADDR_NUMBER-1:0] rf_dest_addr_q, rf_dest_addr_d;
  logic [BIT_NUMBER-1:0]  rf_write_data_q, rf_write_data_d;
  logic                   err_addr_q, err_addr_d;

  logic                   found;
  logic                   transfer;
  logic [PTR_W-1:0]       gnt_idx;
  logic [ADDR_NUMBER-1:0] sel_addr;
  logic [BIT_NUMBER-1:0]  sel_data;
  logic                   addr_legal;

  // Round-robin search: first valid requester at or after the pointer, wrapping; gated by reset/stall.
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && req_valid[(int'(ptr_q) + k) % NUM_REQ]) begin
        found   = 1'b1;
        gnt_idx = PTR_W'((int'(ptr_q) + k) % NUM_REQ);
      end
    end
    transfer  = found && !reset && !stall;
    req_ready = '0;
    if (transfer) begin
      req_ready[gnt_idx] = 1'b1;
    end
  end

  assign sel_addr   = req_addr[int'(gnt_idx)*ADDR_NUMBER +: ADDR_NUMBER];
  assign sel_data   = req_data[int'(gnt_idx)*BIT_NUMBER +: BIT_NUMBER];
  assign addr_legal = ({1'b0, sel_addr} < ADDR_LIMIT);

  // Next state: advance pointer past the winner, load the write or flag an illegal destination.
  always_comb begin
    ptr_d             = ptr_q;
    rf_write_enable_d = 1'b0;
    rf_dest_addr_d    = rf_dest_addr_q;
    rf_write_data_d   = rf_write_data_q;
    err_addr_d        = 1'b0;
    if (transfer) begin
      ptr_d = (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + PTR_W'(1);
      if (addr_legal) begin
        rf_write_enable_d = 1'b1;
        rf_dest_addr_d    = sel_addr;
        rf_write_data_d   = sel_data;
      end else begin
        err_addr_d = 1'b1;
      end
    end
  end

  // State registers; reset drops any write about to be launched.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q             <= '0;
      rf_write_enable_q <= 1'b0;
      rf_dest_addr_q    <= '0;
      rf_write_data_q   <= '0;
      err_addr_q        <= 1'b0;
    end else begin
      ptr_q             <= ptr_d;
      rf_write_enable_q <= rf_write_enable_d;
      rf_dest_addr_q    <= rf_dest_addr_d;
      rf_write_data_q   <= rf_write_data_d;
      err_addr_q        <= err_addr_d;
    end
  end

  assign rf_enable       = 1'b1;
  assign rf_write_enable = rf_write_enable_q;
  assign rf_dest_addr    = rf_dest_addr_q;
  assign rf_write_data   = rf_write_data_q;
  assign err_addr        = err_addr_q;

`ifdef REGFILE_WB_FWD_EN
  // Readers compare against the write currently presented to the register file.
  assign fwd_hit_1 = rf_write_enable_q && (rd_addr_1 == rf_dest_addr_q);
  assign fwd_hit_2 = rf_write_enable_q && (rd_addr_2 == rf_dest_addr_q);
  assign fwd_data  = rf_write_data_q;
`else
  logic unused_rd_addr;
  assign unused_rd_addr = ^{rd_addr_1, rd_addr_2};
  assign fwd_hit_1      = 1'b0;
  assign fwd_hit_2      = 1'b0;
  assign fwd_data       = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed, table-driven bench for regfile_wb_arbiter (default parameters, NUM_REQ=2).
// Each row is applied after a negedge; req_ready is checked before the next posedge,
// registered outputs are checked 1 time unit after it.
module tb_regfile_wb_arbiter;

  localparam int BW = 64;
  localparam int AW = 5;
  localparam int NR = 2;

  localparam logic [63:0] DA   = 64'hAAAA_0000_1111_000A;
  localparam logic [63:0] DB   = 64'hBBBB_2222_3333_000B;
  localparam logic [63:0] DC   = 64'hCCCC_4444_5555_000C;
  localparam logic [63:0] DE   = 64'hEEEE_6666_7777_000E;
  localparam logic [63:0] DF   = 64'hFFFF_8888_9999_000F;
  localparam logic [63:0] DEAD = 64'h0000_0000_0000_DEAD;

  logic              clk;
  logic              reset;
  logic              stall;
  logic [NR-1:0]     req_valid;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*BW-1:0]  req_data;
  logic [NR-1:0]     req_ready;
  logic              rf_enable;
  logic              rf_write_enable;
  logic [AW-1:0]     rf_dest_addr;
  logic [BW-1:0]     rf_write_data;
  logic              err_addr;
  logic [AW-1:0]     rd_addr_1;
  logic [AW-1:0]     rd_addr_2;
  logic              fwd_hit_1;
  logic              fwd_hit_2;
  logic [BW-1:0]     fwd_data;

  int checks = 0;
  int errors = 0;

  regfile_wb_arbiter dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .req_valid       (req_valid),
    .req_addr        (req_addr),
    .req_data        (req_data),
    .req_ready       (req_ready),
    .rf_enable       (rf_enable),
    .rf_write_enable (rf_write_enable),
    .rf_dest_addr    (rf_dest_addr),
    .rf_write_data   (rf_write_data),
    .err_addr        (err_addr),
    .rd_addr_1       (rd_addr_1),
    .rd_addr_2       (rd_addr_2),
    .fwd_hit_1       (fwd_hit_1),
    .fwd_hit_2       (fwd_hit_2),
    .fwd_data        (fwd_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic          rst;
    logic          stl;
    logic [1:0]    vld;
    logic [4:0]    a0;
    logic [4:0]    a1;
    logic [63:0]   d0;
    logic [63:0]   d1;
    logic [1:0]    e_rdy;
    logic          e_we;
    logic [4:0]    e_addr;
    logic [63:0]   e_data;
    logic          e_err;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Registered outputs plus the forwarding view derived from the expected write.
  task automatic chk_outputs(input string tag, input logic e_we, input logic [4:0] e_addr,
                             input logic [63:0] e_data, input logic e_err);
    logic        e_h1, e_h2;
    logic [63:0] e_fd;
`ifdef REGFILE_WB_FWD_EN
    e_h1 = e_we && (rd_addr_1 == e_addr);
    e_h2 = e_we && (rd_addr_2 == e_addr);
    e_fd = e_data;
`else
    e_h1 = 1'b0;
    e_h2 = 1'b0;
    e_fd = '0;
`endif
    chk({tag, " we"},    64'(rf_write_enable), 64'(e_we));
    chk({tag, " addr"},  64'(rf_dest_addr),    64'(e_addr));
    chk({tag, " data"},  rf_write_data,        e_data);
    chk({tag, " err"},   64'(err_addr),        64'(e_err));
    chk({tag, " en"},    64'(rf_enable),       64'd1);
    chk({tag, " hit1"},  64'(fwd_hit_1),       64'(e_h1));
    chk({tag, " hit2"},  64'(fwd_hit_2),       64'(e_h2));
    chk({tag, " fdata"}, fwd_data,             e_fd);
  endtask

  task automatic drive(input logic rst, input logic stl, input logic [1:0] vld,
                       input logic [4:0] a0, input logic [4:0] a1,
                       input logic [63:0] d0, input logic [63:0] d1);
    reset     = rst;
    stall     = stl;
    req_valid = vld;
    req_addr  = {a1, a0};
    req_data  = {d1, d0};
  endtask

  initial begin
    reset     = 1'b1;
    stall     = 1'b0;
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
    rd_addr_1 = 5'd5;
    rd_addr_2 = 5'd6;

    //                rst   stl   vld    a0     a1     d0    d1   rdy    we    addr   data  err
    // reset held, everyone requesting
    vq.push_back(vec_t'{1'b1, 1'b0, 2'b11, 5'd3,  5'd7,  DA,   DB, 2'b00, 1'b0, 5'd0,  64'd0, 1'b0});
    vq.push_back(vec_t'{1'b1, 1'b0, 2'b11, 5'd3,  5'd7,  DA,   DB, 2'b00, 1'b0, 5'd0,  64'd0, 1'b0});
    // both valid: alternate 0,1,0,1
    vq.push_back(vec_t'{1'b0, 1'b0, 2'b11, 5'd3,  5'd7,  DA,   DB, 2'b01, 1'b1, 5'd3,  DA,    1'b0});
    vq.push_back(vec_t'{1'b0, 1'b0, 2'b11, 5'd3,  5'd7,  DA,   DB, 2'b10, 1'b1, 5'd7,  DB,    1'b0});
    vq.push_back(vec_t'{1'b0, 1'b0, 2'b11, 5'd3,  5'd7,  DA,   DB, 2'b01, 1'b1, 5'd3,  DA,    1'b0});
    vq.push_back(vec_t'{1'b0, 1'b0, 2'b11, 5'd3,  5'd7,  DA,   DB, 2'b10, 1'b1, 5'd7,  DB,    1'b0});
    // requester 1 alone, illegal address 20: err for one cycle, outputs hold
    vq.push_back(vec_t'{1'b0, 1'b0, 2'b10, 5'd3,  5'd20, DA,   DC, 2'b10, 1'b0, 5'd7,  DB,    1'b1});
    vq.push_back(vec_t'{1'b0, 1'b0, 2'b00, 5'd3,  5'd7,  DA,   DB, 2'b00, 1'b0, 5'd7,  DB,    1'b0});
    // move pointer to 1, then stall 3 cycles; grant after stall goes to 1 (pointer preserved)
    vq.push_back(vec_t'{1'b0, 1'b0, 2'b01, 5'd4,  5'd7,  DC,   DB, 2'b01, 1'b1, 5'd4,  DC,    1'b0});
    vq.push_back(vec_t'{1'b0, 1'b1, 2'b11, 5'd3,  5'd7,  DA,   DB, 2'b00, 1'b0, 5'd4,  DC,    1'b0});
    vq.push_back(vec_t'{1'b0, 1'b1, 2'b11, 5'd3,  5'd7,  DA,   DB, 2'b00, 1'b0, 5'd4,  DC,    1'b0});
    vq.push_back(vec_t'{1'b0, 1'b1, 2'b11, 5'd3,  5'd7,  DA,   DB, 2'b00, 1'b0, 5'd4,  DC,    1'b0});
    vq.push_back(vec_t'{1'b0, 1'b0, 2'b11, 5'd3,  5'd7,  DA,   DB, 2'b10, 1'b1, 5'd7,  DB,    1'b0});
    // write 5 <- DEAD in flight while rd_addr_1=5, rd_addr_2=6
    vq.push_back(vec_t'{1'b0, 1'b0, 2'b01, 5'd5,  5'd7,  DEAD, DB, 2'b01, 1'b1, 5'd5,  DEAD,  1'b0});
    // pointer=1 but only requester 0 valid: still granted
    vq.push_back(vec_t'{1'b0, 1'b0, 2'b01, 5'd10, 5'd7,  DF,   DB, 2'b01, 1'b1, 5'd10, DF,    1'b0});
    // reset right after that grant: write dropped, pointer back to 0
    vq.push_back(vec_t'{1'b1, 1'b0, 2'b11, 5'd3,  5'd7,  DA,   DB, 2'b00, 1'b0, 5'd0,  64'd0, 1'b0});
    vq.push_back(vec_t'{1'b0, 1'b0, 2'b11, 5'd3,  5'd7,  DA,   DB, 2'b01, 1'b1, 5'd3,  DA,    1'b0});
    // write to 6 hits read port 2
    vq.push_back(vec_t'{1'b0, 1'b0, 2'b10, 5'd3,  5'd6,  DA,   DE, 2'b10, 1'b1, 5'd6,  DE,    1'b0});
    // address boundary: 15 legal, 16 illegal
    vq.push_back(vec_t'{1'b0, 1'b0, 2'b01, 5'd15, 5'd7,  DC,   DB, 2'b01, 1'b1, 5'd15, DC,    1'b0});
    vq.push_back(vec_t'{1'b0, 1'b0, 2'b10, 5'd3,  5'd16, DA,   DE, 2'b10, 1'b0, 5'd15, DC,    1'b1});
    vq.push_back(vec_t'{1'b0, 1'b0, 2'b00, 5'd3,  5'd7,  DA,   DB, 2'b00, 1'b0, 5'd15, DC,    1'b0});

    for (int i = 0; i < vq.size(); i++) begin
      string tag;
      tag = $sformatf("row%0d", i);
      @(negedge clk);
      drive(vq[i].rst, vq[i].stl, vq[i].vld, vq[i].a0, vq[i].a1, vq[i].d0, vq[i].d1);
      #1;
      chk({tag, " ready"}, 64'(req_ready), 64'(vq[i].e_rdy));
      @(posedge clk);
      #1;
      chk_outputs(tag, vq[i].e_we, vq[i].e_addr, vq[i].e_data, vq[i].e_err);
    end

    // Hand sequence: requester 0 waits through a 3-cycle stall (pointer is 0 here),
    // then must be granted in the first unstalled cycle.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      drive(1'b0, 1'b1, 2'b01, 5'd2, 5'd7, DC, DB);
      #1;
      chk("stall ready", 64'(req_ready), 64'd0);
      @(posedge clk);
      #1;
      chk_outputs("stall", 1'b0, 5'd15, DC, 1'b0);
    end
    @(negedge clk);
    drive(1'b0, 1'b0, 2'b01, 5'd2, 5'd7, DC, DB);
    begin
      int waited;
      waited = 0;
      #1;
      while (req_ready != 2'b01 && waited < 4) begin
        @(negedge clk);
        #1;
        waited++;
      end
      chk("unstall grant delay", 64'(waited), 64'd0);
      chk("unstall ready", 64'(req_ready), 64'(2'b01));
    end
    @(posedge clk);
    #1;
    chk_outputs("unstall", 1'b1, 5'd2, DC, 1'b0);

    // Idle after the write: enable drops, write held
    @(negedge clk);
    drive(1'b0, 1'b0, 2'b00, 5'd0, 5'd0, 64'd0, 64'd0);
    @(posedge clk);
    #1;
    chk_outputs("idle", 1'b0, 5'd2, DC, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
